key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Converts the debounced, active-low key levels from the key debouncer into single-cycle event pulses: press, release, long-press and auto-repeat. It sits between the debouncer and the application control logic, and runs entirely on the system clock. Its ms timebase is an internal 1 kHz tick enable, not a derived clock. The application logic consumes one-cycle strobes and never needs to edge-detect key levels itself.

## Interface
Parameters:
- N_KEYS, 2, number of independent key channels.
- CLK_DIV, 50000, Sys_CLK cycles per 1 ms tick (50 MHz board clock).
- LONG_MS, 1000, hold time in ticks before Key_Long fires (1 to 65535).
- REPEAT_MS, 200, interval in ticks between Key_Repeat pulses after Key_Long (1 to 65535).

Ports:
- Sys_CLK, input, 1, system clock; the only clock.
- Sys_RST, input, 1, reset, synchronous and active-high.
- Key_Level, input, N_KEYS, debounced key levels; 0 = pressed. Asynchronous to Sys_CLK because the debouncer runs on its divided clock.
- Key_Press, output, N_KEYS, one-cycle pulse on the press edge.
- Key_Release, output, N_KEYS, one-cycle pulse on the release edge.
- Key_Long, output, N_KEYS, one-cycle pulse once per press, after LONG_MS ticks held.
- Key_Repeat, output, N_KEYS, one-cycle pulse every REPEAT_MS ticks after Key_Long while the key stays held.
- Key_Held, output, N_KEYS, level; 1 while the channel is in any pressed state.

## Operation
- Synchronizer: each Key_Level bit passes through a 2-flop synchronizer. Both flops reset to 1 (released). All logic below uses the synchronized value `s`.
- Prescaler: a 16-bit counter counts 0 to CLK_DIV-1 and wraps. Tick = 1 for the one cycle where count == CLK_DIV-1. A single prescaler is shared by all channels.
- Per-channel FSM with a 16-bit timer. The timer is cleared on every state entry and increments on Tick, saturating at 0xFFFF.
  - IDLE: on s == 0, go to PRESS, pulse Key_Press, clear timer.
  - PRESS: on s == 1, go to IDLE and pulse Key_Release. Otherwise, on Tick with timer == LONG_MS-1, go to LONG, pulse Key_Long, clear timer.
  - LONG: on s == 1, go to IDLE and pulse Key_Release. Otherwise, on Tick with timer == REPEAT_MS-1, pulse Key_Repeat, clear timer and stay in LONG.
- Key_Held = 1 in PRESS and LONG, 0 in IDLE.
- Simultaneous release and timer expiry in the same cycle: release wins. Only Key_Release fires; there is no Key_Long or Key_Repeat pulse.
- Channels are fully independent. Any combination of channels may pulse in the same cycle.
- Key_Release never fires without a preceding Key_Press.
- Key_Press and Key_Long never fire in the same cycle.

## Timing
- Reset state: all outputs 0, FSMs in IDLE, timers 0, prescaler 0, synchronizer flops 1.
- Reset asserted mid-operation: same reset state on the next edge. No Key_Release is emitted for a key that was held.
- Key held through reset deassertion: Key_Press fires 3 cycles after Sys_RST falls (2 synchronizer cycles + 1 FSM cycle).
- Press/release latency: an edge on Key_Level produces the matching pulse in the 3rd Sys_CLK cycle after the edge is sampled.
- All outputs are registered. Each pulse is exactly 1 cycle wide.
- Long-press latency: between LONG_MS-1 and LONG_MS ticks after the press edge. The uncertainty comes from the free-running prescaler phase.
- Repeat spacing: exactly REPEAT_MS × CLK_DIV cycles between consecutive Key_Repeat pulses, and between Key_Long and the first Key_Repeat.

## Structure
- Shared package key_pkg holds:
  - the FSM state encoding constants (IDLE = 2'd0, PRESS = 2'd1, LONG = 2'd2);
  - the timer width constant (16).
- Sub-module key_event_fsm implements one channel: its FSM, timer and output registers. It takes Tick and the synchronized level as inputs. The top instantiates N_KEYS copies plus one prescaler and the synchronizer array.

## Test plan
Use CLK_DIV=4, LONG_MS=3, REPEAT_MS=2 unless stated.
- Reset with Key_Level = 2'b11 for 10 cycles -> all outputs 0, Key_Held = 0.
- Drop Key_Level[0] to 0 for 6 cycles, then raise it -> Key_Press[0] 1 cycle wide, 3 cycles after the fall. Key_Release[0] 3 cycles after the rise. No Key_Long. Channel 1 stays silent.
- Hold Key_Level[1] = 0 for 40 cycles -> Key_Press[1], then Key_Long[1] within 9 to 12 cycles of the press, then Key_Repeat[1] every 8 cycles. Key_Held[1] = 1 throughout.
- Release timed so the synchronized rise coincides with the Tick that would fire Key_Long -> only Key_Release fires and the FSM returns to IDLE.
- Assert Sys_RST for 1 cycle while channel 0 is in LONG and the key is still held -> outputs clear with no Key_Release. Key_Press[0] fires 3 cycles after reset is released.
- Press both keys in the same cycle -> Key_Press = 2'b11 in the same cycle, and Key_Long on both channels in the same cycle.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and timer width for the key event decoder
package key_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_event_fsm.sv
// rtl/key_event_fsm.sv - one key channel: press/release/long/repeat FSM with a tick timer
module key_event_fsm
  import key_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt,
  output logic repeat_evt,
  output logic held
);

  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_MS - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_MS - 1);

  key_state_e         state;
  logic [TIMER_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
      repeat_evt  <= 1'b0;
      if (tick && timer != '1) timer <= timer + TIMER_W'(1);

      // Release is tested before expiry so a release on the expiring tick suppresses long/repeat.
      case (state)
        IDLE: begin
          timer <= '0;
          if (!level) begin
            state     <= PRESS;
            press_evt <= 1'b1;
            held      <= 1'b1;
          end
        end
        PRESS: begin
          if (level) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            held        <= 1'b0;
            timer       <= '0;
          end else if (tick && timer == LONG_LAST) begin
            state    <= LONG;
            long_evt <= 1'b1;
            timer    <= '0;
          end
        end
        LONG: begin
          if (level) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            held        <= 1'b0;
            timer       <= '0;
          end else if (tick && timer == REPEAT_LAST) begin
            repeat_evt <= 1'b1;
            timer      <= '0;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - synchronizes key levels, shares a ms prescaler, fans out per-key FSMs
module key_event_decoder
  import key_pkg::*;
#(
  parameter int N_KEYS    = 2,
  parameter int CLK_DIV   = 50000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Key_Press,
  output logic [N_KEYS-1:0] Key_Release,
  output logic [N_KEYS-1:0] Key_Long,
  output logic [N_KEYS-1:0] Key_Repeat,
  output logic [N_KEYS-1:0] Key_Held
);

  localparam logic [TIMER_W-1:0] DIV_LAST = TIMER_W'(CLK_DIV - 1);

  logic [N_KEYS-1:0]  sync_meta;
  logic [N_KEYS-1:0]  sync_lvl;
  logic [TIMER_W-1:0] div_count;
  logic               tick;

  // Synchronizer resets to released so a held key produces a fresh press after reset.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      sync_meta <= '1;
      sync_lvl  <= '1;
    end else begin
      sync_meta <= Key_Level;
      sync_lvl  <= sync_meta;
    end
  end

  assign tick = (div_count == DIV_LAST);

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST)   div_count <= '0;
    else if (tick) div_count <= '0;
    else           div_count <= div_count + TIMER_W'(1);
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_event_fsm #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_fsm (
      .clk        (Sys_CLK),
      .rst        (Sys_RST),
      .tick       (tick),
      .level      (sync_lvl[i]),
      .press_evt  (Key_Press[i]),
      .release_evt(Key_Release[i]),
      .long_evt   (Key_Long[i]),
      .repeat_evt (Key_Repeat[i]),
      .held       (Key_Held[i])
    );
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed and random checks of key_event_decoder against an event model
module tb_key_event_decoder;

  localparam int N_KEYS    = 2;
  localparam int CLK_DIV   = 4;
  localparam int LONG_MS   = 3;
  localparam int REPEAT_MS = 2;

  logic              Sys_CLK = 1'b0;
  logic              Sys_RST = 1'b1;
  logic [N_KEYS-1:0] Key_Level = '1;
  logic [N_KEYS-1:0] Key_Press, Key_Release, Key_Long, Key_Repeat, Key_Held;

  int checks   = 0;
  int failures = 0;

  key_event_decoder #(
    .N_KEYS   (N_KEYS),
    .CLK_DIV  (CLK_DIV),
    .LONG_MS  (LONG_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .Sys_CLK    (Sys_CLK),
    .Sys_RST    (Sys_RST),
    .Key_Level  (Key_Level),
    .Key_Press  (Key_Press),
    .Key_Release(Key_Release),
    .Key_Long   (Key_Long),
    .Key_Repeat (Key_Repeat),
    .Key_Held   (Key_Held)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  // Model: levels sampled per edge since reset, held flag and ticks elapsed since the press.
  logic [N_KEYS-1:0] hist[$];
  int                edge_k = 0;
  bit                pressed[N_KEYS];
  int                ticks[N_KEYS];
  logic [N_KEYS-1:0] e_press, e_rel, e_long, e_rep, e_held;

  int cyc = 0;
  int n_press[N_KEYS], n_rel[N_KEYS], n_long[N_KEYS], n_rep[N_KEYS];
  int last_press[N_KEYS], last_long[N_KEYS];
  bit both_press_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [N_KEYS-1:0] lvl);
    logic s;
    bit   tk;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    if (rst) begin
      hist.delete();
      edge_k = 0;
      for (int i = 0; i < N_KEYS; i++) begin pressed[i] = 0; ticks[i] = 0; end
      e_held = '0;
    end else begin
      hist.push_back(lvl);
      tk = (edge_k % CLK_DIV) == CLK_DIV - 1;
      for (int i = 0; i < N_KEYS; i++) begin
        s = (edge_k >= 2) ? hist[edge_k-2][i] : 1'b1;
        if (!pressed[i]) begin
          if (!s) begin pressed[i] = 1; ticks[i] = 0; e_press[i] = 1'b1; end
        end else if (s) begin
          pressed[i] = 0; e_rel[i] = 1'b1;
        end else if (tk) begin
          ticks[i]++;
          if (ticks[i] == LONG_MS) e_long[i] = 1'b1;
          else if (ticks[i] > LONG_MS && (ticks[i] - LONG_MS) % REPEAT_MS == 0) e_rep[i] = 1'b1;
        end
        e_held[i] = pressed[i];
      end
      edge_k++;
    end
  endtask

  task automatic cycle(input logic rst, input logic [N_KEYS-1:0] lvl);
    int this_edge;
    Sys_RST   = rst;
    Key_Level = lvl;
    @(posedge Sys_CLK);
    this_edge = cyc;
    cyc++;
    model_edge(rst, lvl);
    @(negedge Sys_CLK);
    chk($sformatf("press@%0d", this_edge), Key_Press, e_press);
    chk($sformatf("release@%0d", this_edge), Key_Release, e_rel);
    chk($sformatf("long@%0d", this_edge), Key_Long, e_long);
    chk($sformatf("repeat@%0d", this_edge), Key_Repeat, e_rep);
    chk($sformatf("held@%0d", this_edge), Key_Held, e_held);
    if (Key_Press == '1) both_press_seen = 1;
    for (int i = 0; i < N_KEYS; i++) begin
      if (Key_Press[i])   begin n_press[i]++; last_press[i] = this_edge; end
      if (Key_Release[i]) n_rel[i]++;
      if (Key_Long[i])    begin n_long[i]++; last_long[i] = this_edge; end
      if (Key_Repeat[i])  n_rep[i]++;
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N_KEYS; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
      last_press[i] = -1; last_long[i] = -1;
    end
    both_press_seen = 0;
  endtask

  initial begin
    int c0;
    bit found;
    logic [N_KEYS-1:0] lvl;

    clr_counts();

    // Reset with keys released.
    for (int n = 0; n < 10; n++) cycle(1'b1, 2'b11);
    chk("reset_held", Key_Held, 0);
    chk("reset_press", Key_Press, 0);
    cycle(1'b0, 2'b11);
    cycle(1'b0, 2'b11);

    // Short press on key 0.
    clr_counts();
    c0 = cyc;
    for (int n = 0; n < 6; n++) cycle(1'b0, 2'b10);
    for (int n = 0; n < 8; n++) cycle(1'b0, 2'b11);
    chk("short_press_cnt", n_press[0], 1);
    chk("short_press_lat", last_press[0] - c0, 2);
    chk("short_release_cnt", n_rel[0], 1);
    chk("short_long_cnt", n_long[0], 0);
    chk("short_ch1_silent", n_press[1] + n_rel[1], 0);

    // Long hold on key 1.
    clr_counts();
    for (int n = 0; n < 40; n++) cycle(1'b0, 2'b01);
    chk("hold_press_cnt", n_press[1], 1);
    chk("hold_long_cnt", n_long[1], 1);
    chk("hold_long_lat", (last_long[1] - last_press[1] >= 9) && (last_long[1] - last_press[1] <= 12), 1);
    chk("hold_repeat_cnt", n_rep[1], 3);
    chk("hold_held", Key_Held[1], 1);
    for (int n = 0; n < 6; n++) cycle(1'b0, 2'b11);

    // Release coinciding with the long-press tick.
    clr_counts();
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (pressed[0] && ticks[0] == LONG_MS - 1 && ((edge_k + 2) % CLK_DIV) == CLK_DIV - 1) found = 1;
      else cycle(1'b0, 2'b10);
    end
    chk("race_found", found, 1);
    for (int n = 0; n < 6; n++) cycle(1'b0, 2'b11);
    chk("race_long_cnt", n_long[0], 0);
    chk("race_release_cnt", n_rel[0], 1);
    chk("race_idle", Key_Held[0], 0);

    // Reset while key 0 is in long-press and still held.
    clr_counts();
    for (int n = 0; n < 30 && n_long[0] == 0; n++) cycle(1'b0, 2'b10);
    chk("rst_reached_long", n_long[0], 1);
    cycle(1'b0, 2'b10);
    cycle(1'b1, 2'b10);
    chk("rst_mid_held", Key_Held, 0);
    clr_counts();
    c0 = cyc;
    for (int n = 0; n < 5; n++) cycle(1'b0, 2'b10);
    chk("rst_no_release", n_rel[0], 0);
    chk("rst_repress_lat", last_press[0] - c0, 2);
    for (int n = 0; n < 6; n++) cycle(1'b0, 2'b11);

    // Both keys pressed together.
    clr_counts();
    for (int n = 0; n < 20; n++) cycle(1'b0, 2'b00);
    chk("both_press", both_press_seen, 1);
    chk("both_long_same", last_long[0] == last_long[1] && last_long[0] >= 0, 1);
    for (int n = 0; n < 6; n++) cycle(1'b0, 2'b11);

    // Random levels with occasional resets.
    lvl = 2'b11;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N_KEYS; i++)
        if ($urandom_range(0, 6) == 0) lvl[i] = ~lvl[i];
      cycle(($urandom_range(0, 99) == 0), lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
